// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n: WIDTH-generic universal shift register with
// rotate, arithmetic shift, register clear, a serial-out tap and a counted
// burst engine (start/busy/done handshake).
// Optional feature macro: USR_ROTATE_EN (modes 100/101 rotate when defined,
// otherwise they hold A_par and ser_out).
module universal_shift_register_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] A_par,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_ZERO = 3'b111;

  state_t           r_state;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_next_a;
  logic             w_next_ser;

  // During a burst the latched mode drives the shifter; otherwise the live mode.
  assign w_op = (r_state == S_RUN) ? r_mode : mode;

  // Shifter datapath: next register value and serial-out tap for the selected op.
  always_comb begin
    w_next_a   = r_a;
    w_next_ser = r_ser;
    case (w_op)
      M_HOLD: begin
      end
      M_SHR: begin
        w_next_a   = {MSB_in, r_a[WIDTH-1:1]};
        w_next_ser = r_a[0];
      end
      M_SHL: begin
        w_next_a   = {r_a[WIDTH-2:0], LSB_in};
        w_next_ser = r_a[WIDTH-1];
      end
      M_LOAD: begin
        w_next_a = I_par;
      end
`ifdef USR_ROTATE_EN
      M_ROR: begin
        w_next_a   = {r_a[0], r_a[WIDTH-1:1]};
        w_next_ser = r_a[0];
      end
      M_ROL: begin
        w_next_a   = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
        w_next_ser = r_a[WIDTH-1];
      end
`else
      M_ROR, M_ROL: begin
      end
`endif
      M_ASR: begin
        w_next_a   = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_next_ser = r_a[0];
      end
      M_ZERO: begin
        w_next_a = '0;
      end
    endcase
  end

  // Burst FSM and register update; clear wins over everything and aborts a burst silently.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_mode  <= M_HOLD;
      r_cnt   <= '0;
      r_a     <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (steps != '0) begin
              r_mode  <= mode;
              r_cnt   <= steps;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end else begin
            r_a   <= w_next_a;
            r_ser <= w_next_ser;
          end
        end
        S_RUN: begin
          r_a   <= w_next_a;
          r_ser <= w_next_ser;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A_par   = r_a;
  assign ser_out = r_ser;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Self-checking bench for universal_shift_register_n (WIDTH=8, CNT_W=4).
// Expected values come from a behavioural cycle model and are queued per
// driven cycle, then popped and compared one time unit after the clock edge.
module tb_universal_shift_register_n;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] I_par = 8'h00;
  logic       MSB_in = 1'b0;
  logic       LSB_in = 1'b0;
  logic       start = 1'b0;
  logic [3:0] steps = 4'd0;
  logic [7:0] A_par;
  logic       ser_out;
  logic       busy;
  logic       done;

  universal_shift_register_n #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clear(clear), .mode(mode), .I_par(I_par),
    .MSB_in(MSB_in), .LSB_in(LSB_in), .start(start), .steps(steps),
    .A_par(A_par), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic       ser;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic       clr;
    logic [2:0] md;
    logic [7:0] ip;
    logic       msb;
    logic       lsb;
    logic       st;
    logic [3:0] stp;
  } stim_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // behavioural model state
  logic [7:0] m_a = 8'h00;
  logic       m_ser = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [2:0] m_mode = 3'd0;
  int         m_left = 0;

  function automatic stim_t mk(input logic c, input logic [2:0] md, input logic [7:0] ip,
                               input logic msb, input logic lsb, input logic st, input logic [3:0] stp);
    stim_t s;
    s.clr = c; s.md = md; s.ip = ip; s.msb = msb; s.lsb = lsb; s.st = st; s.stp = stp;
    return s;
  endfunction

  function automatic logic [8:0] f_apply(input logic [2:0] op, input logic [7:0] a, input logic s,
                                         input logic [7:0] ip, input logic msb, input logic lsb);
    logic [8:0] r;
    r = {a, s};
    case (op)
      3'd1: r = {(a >> 1) | {msb, 7'b0}, a[0]};
      3'd2: r = {(a << 1) | {7'b0, lsb}, a[7]};
      3'd3: r = {ip, s};
`ifdef USR_ROTATE_EN
      3'd4: r = {(a >> 1) | {a[0], 7'b0}, a[0]};
      3'd5: r = {(a << 1) | {7'b0, a[7]}, a[7]};
`endif
      3'd6: r = {(a >> 1) | {a[7], 7'b0}, a[0]};
      3'd7: r = {8'h00, s};
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input stim_t s);
    clear = s.clr; mode = s.md; I_par = s.ip; MSB_in = s.msb;
    LSB_in = s.lsb; start = s.st; steps = s.stp;
  endtask

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    if (clear) begin
      m_a = 8'h00; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      {m_a, m_ser} = f_apply(m_mode, m_a, m_ser, I_par, MSB_in, LSB_in);
      m_left = m_left - 1;
      m_busy = (m_left > 0);
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      m_busy = 1'b0;
      if (start) begin
        if (steps == 4'd0) m_done = 1'b1;
        else begin
          m_mode = mode; m_left = int'(steps); m_busy = 1'b1;
        end
      end else begin
        {m_a, m_ser} = f_apply(mode, m_a, m_ser, I_par, MSB_in, LSB_in);
      end
    end
    sb.push_back({m_a, m_ser, m_busy, m_done});
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 3'd3, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd5));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({A_par, ser_out, busy, done} !== 11'h000) begin
        n_errors++;
        $display("FAIL reset[%0d]: got a=%h ser=%b busy=%b done=%b want all zero", i, A_par, ser_out, busy, done);
      end
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL reset_model[%0d]: got %h want %h", i, {A_par, ser_out, busy, done}, e);
      end
    end
  endtask

  task automatic test_load();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b0, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL load[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
    end
    n_checks++;
    if ({A_par, ser_out} !== {8'hA5, 1'b0}) begin
      n_errors++;
      $display("FAIL load_value: got a=%h ser=%b want a=a5 ser=0", A_par, ser_out);
    end
  endtask

  task automatic test_direct_shift();
    stim_t      s[$];
    exp_t       e;
    logic [8:0] got[$];
    s.push_back(mk(1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd0, 8'h3C, 1'b0, 1'b1, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd7, 8'h3C, 1'b0, 1'b1, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      got.push_back({A_par, ser_out});
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL direct_shift[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
    end
    n_checks++;
    if (got[0] !== {8'hD2, 1'b1}) begin
      n_errors++; $display("FAIL shr_value: got %h want %h", got[0], {8'hD2, 1'b1});
    end
    n_checks++;
    if (got[1] !== {8'hA4, 1'b1}) begin
      n_errors++; $display("FAIL shl_value: got %h want %h", got[1], {8'hA4, 1'b1});
    end
    n_checks++;
    if (got[3] !== {8'h00, 1'b1}) begin
      n_errors++; $display("FAIL zero_mode_keeps_ser: got %h want %h", got[3], {8'h00, 1'b1});
    end
  endtask

  task automatic test_rotate_burst();
    stim_t      s[$];
    exp_t       e;
    logic [8:0] want;
    int         n_done = 0, n_busy = 0;
`ifdef USR_ROTATE_EN
    want = {8'h30, 1'b0};
`else
    want = {8'h81, 1'b1};
`endif
    s.push_back(mk(1'b0, 3'd3, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3));
    repeat (3) s.push_back(mk(1'b0, 3'd3, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd5));
    s.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      if (done) n_done++;
      if (busy) n_busy++;
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL rotate_burst[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
      if (i == 4) begin
        n_checks++;
        if ({A_par, ser_out, done} !== {want, 1'b1}) begin
          n_errors++;
          $display("FAIL rotate_final: got a=%h ser=%b done=%b want %h done=1", A_par, ser_out, done, want);
        end
      end
    end
    n_checks++;
    if (n_done != 1 || n_busy != 3) begin
      n_errors++; $display("FAIL rotate_handshake: got done=%0d busy=%0d cycles want 1 and 3", n_done, n_busy);
    end
  endtask

  task automatic test_arith_burst();
    stim_t s[$];
    exp_t  e;
    int    n_done = 0;
    s.push_back(mk(1'b0, 3'd3, 8'h90, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2));
    repeat (2) s.push_back(mk(1'b0, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      if (done) n_done++;
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL arith_burst[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
    end
    n_checks++;
    if ({A_par, ser_out} !== {8'hE4, 1'b0} || n_done != 1) begin
      n_errors++; $display("FAIL arith_final: got a=%h ser=%b done_count=%0d want a=e4 ser=0 done_count=1", A_par, ser_out, n_done);
    end
  endtask

  task automatic test_zero_burst();
    stim_t s[$];
    exp_t  e;
    int    n_done = 0, n_busy = 0;
    s.push_back(mk(1'b0, 3'd3, 8'h11, 1'b0, 1'b0, 1'b1, 4'd0));
    repeat (2) s.push_back(mk(1'b0, 3'd0, 8'h22, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      if (done) n_done++;
      if (busy) n_busy++;
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL zero_burst[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
    end
    n_checks++;
    if (A_par !== 8'hE4 || n_done != 1 || n_busy != 0) begin
      n_errors++; $display("FAIL zero_burst_summary: got a=%h done=%0d busy=%0d want a=e4 done=1 busy=0", A_par, n_done, n_busy);
    end
  endtask

  task automatic test_abort();
    stim_t s[$];
    exp_t  e;
    int    n_done = 0, done_at = -1;
    s.push_back(mk(1'b0, 3'd3, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8));
    repeat (2) s.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2));
    s.push_back(mk(1'b0, 3'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      if (done) begin n_done++; done_at = i; end
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL abort[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
      if (i == 3) begin
        n_checks++;
        if ({A_par, busy} !== {8'hFC, 1'b1}) begin
          n_errors++; $display("FAIL abort_pre_clear: got a=%h busy=%b want a=fc busy=1", A_par, busy);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({A_par, ser_out, busy, done} !== 11'h000) begin
          n_errors++; $display("FAIL abort_clear: got a=%h ser=%b busy=%b done=%b want all zero", A_par, ser_out, busy, done);
        end
      end
    end
    n_checks++;
    if (n_done != 1 || done_at != 7 || A_par !== 8'h3C) begin
      n_errors++; $display("FAIL abort_restart: got done=%0d at %0d a=%h want done=1 at 7 a=3c", n_done, done_at, A_par);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    exp_t  e;
    int    n_done = 0, n_busy = 0;
    s.push_back(mk(1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd1));
    s.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 4'd15));
    repeat (15) s.push_back(mk(1'b0, 3'd3, 8'hAA, 1'b1, 1'b1, 1'b1, 4'd3));
    s.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      if (done) n_done++;
      if (busy) n_busy++;
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
    end
    n_checks++;
    if (n_done != 2 || n_busy != 16) begin
      n_errors++; $display("FAIL back_to_back_handshake: got done=%0d busy=%0d want done=2 busy=16", n_done, n_busy);
    end
  endtask

  task automatic test_direct_random();
    stim_t s[$];
    exp_t  e;
    for (int k = 0; k < 40; k++)
      s.push_back(mk(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]); model_edge();
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({A_par, ser_out, busy, done} !== e) begin
        n_errors++;
        $display("FAIL direct_random[%0d] mode=%0d: got a=%h ser=%b busy=%b done=%b want a=%h ser=%b busy=%b done=%b",
                 i, s[i].md, A_par, ser_out, busy, done, e.a, e.ser, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_direct_shift();
    test_rotate_burst();
    test_arith_burst();
    test_zero_burst();
    test_abort();
    test_back_to_back();
    test_direct_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
